// File: rtl/keypad_debouncer.sv
`default_nettype none
// ==========================================================================
// keypad_debouncer : synchronise, debounce and one-key-lock the ten oven keys
// Revision 1.0
// ==========================================================================
module keypad_debouncer #(
  parameter int NUM_KEYS        = 10,
  parameter int DEBOUNCE_CYCLES = 3
) (
  input  logic                clock,
  input  logic                clearn,
  input  logic [NUM_KEYS-1:0] raw_keys,
  input  logic                enablen,
  output logic [NUM_KEYS-1:0] keypad,
  output logic [3:0]          key_code,
  output logic                key_valid,
  output logic                key_held
);

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    DEB_PRESS   = 2'd1,
    PRESSED     = 2'd2,
    DEB_RELEASE = 2'd3
  } state_t;

  localparam logic [3:0]          DEB_LAST = 4'(DEBOUNCE_CYCLES);
  localparam logic [NUM_KEYS-1:0] ONE      = NUM_KEYS'(1);

  state_t              state, state_n;
  logic [NUM_KEYS-1:0] sync1, sync2;
  logic [NUM_KEYS-1:0] cand, cand_n;
  logic [3:0]          count, count_n, count_inc;
  logic [NUM_KEYS-1:0] keypad_n;
  logic [3:0]          key_code_n;
  logic                key_valid_n, key_held_n;
  logic                s_onehot, s_match;

  function automatic logic [3:0] key_index(input logic [NUM_KEYS-1:0] v);
    logic [3:0] idx;
    idx = 4'hF;
    for (int i = 0; i < NUM_KEYS; i++) begin
      if (v[i]) idx = 4'(i);
    end
    return idx;
  endfunction

  assign s_onehot  = (sync2 != '0) && ((sync2 & (sync2 - ONE)) == '0);
  assign s_match   = (sync2 == cand);
  assign count_inc = (count == 4'hF) ? count : count + 4'd1;

  always_ff @(posedge clock) begin
    if (!clearn) begin
      sync1     <= '0;
      sync2     <= '0;
      state     <= IDLE;
      cand      <= '0;
      count     <= 4'd0;
      keypad    <= '0;
      key_code  <= 4'hF;
      key_valid <= 1'b0;
      key_held  <= 1'b0;
    end else begin
      sync1     <= raw_keys;
      sync2     <= sync1;
      state     <= state_n;
      cand      <= cand_n;
      count     <= count_n;
      keypad    <= keypad_n;
      key_code  <= key_code_n;
      key_valid <= key_valid_n;
      key_held  <= key_held_n;
    end
  end

  always_comb begin
    state_n     = state;
    cand_n      = cand;
    count_n     = count;
    keypad_n    = keypad;
    key_code_n  = key_code;
    key_valid_n = 1'b0;
    case (state)
      IDLE: begin
        if (!enablen && s_onehot) begin
          cand_n  = sync2;
          count_n = 4'd1;
          state_n = DEB_PRESS;
        end
      end
      DEB_PRESS: begin
        if (enablen || !s_match) begin
          count_n = 4'd0;
          state_n = IDLE;
        end else if (count_inc == DEB_LAST) begin
          count_n     = 4'd0;
          keypad_n    = cand;
          key_code_n  = key_index(cand);
          key_valid_n = 1'b1;
          state_n     = PRESSED;
        end else begin
          count_n = count_inc;
        end
      end
      PRESSED: begin
        // Any deviation from the locked key, including a second key, starts a release.
        if (!s_match) begin
          count_n = 4'd1;
          state_n = DEB_RELEASE;
        end
      end
      DEB_RELEASE: begin
        if (s_match) begin
          count_n = 4'd0;
          state_n = PRESSED;
        end else if (count_inc == DEB_LAST) begin
          count_n    = 4'd0;
          keypad_n   = '0;
          key_code_n = 4'hF;
          state_n    = IDLE;
        end else begin
          count_n = count_inc;
        end
      end
      default: begin
        count_n = 4'd0;
        state_n = IDLE;
      end
    endcase
    key_held_n = (state_n == PRESSED) || (state_n == DEB_RELEASE);
  end

endmodule
`default_nettype wire

// File: tb/tb_keypad_debouncer.sv
`default_nettype none
`timescale 1ns/1ps
// ==========================================================================
// tb_keypad_debouncer : vector table, directed corner sequences and random
// stimulus against a run-length reference model
// ==========================================================================
module tb_keypad_debouncer;
  localparam int NK = 10;
  localparam int D  = 3;

  logic          clock    = 1'b0;
  logic          clearn   = 1'b0;
  logic          enablen  = 1'b0;
  logic [NK-1:0] raw_keys = '0;
  logic [NK-1:0] keypad;
  logic [3:0]    key_code;
  logic          key_valid;
  logic          key_held;

  keypad_debouncer #(.NUM_KEYS(NK), .DEBOUNCE_CYCLES(D)) dut (
    .clock    (clock),
    .clearn   (clearn),
    .raw_keys (raw_keys),
    .enablen  (enablen),
    .keypad   (keypad),
    .key_code (key_code),
    .key_valid(key_valid),
    .key_held (key_held)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: a delay line for the synchroniser plus run lengths of
  // qualifying samples for press and non-matching samples for release.
  logic [NK-1:0] m_d1 = '0, m_d2 = '0;
  bit            m_held  = 0;
  int            m_key   = 0;
  int            m_cand  = -1;
  int            m_run   = 0;
  int            m_rel   = 0;
  bit            m_valid = 0;

  function automatic int single_index(input logic [NK-1:0] v);
    if ($countones(v) != 1) return -1;
    for (int i = 0; i < NK; i++) if (v[i]) return i;
    return -1;
  endfunction

  function automatic logic [NK-1:0] m_keypad();
    logic [NK-1:0] one;
    one = NK'(1);
    return m_held ? (one << m_key) : '0;
  endfunction

  task automatic model_edge(input logic [NK-1:0] r, input logic en, input logic clr);
    int k;
    logic [NK-1:0] one;
    one = NK'(1);
    m_valid = 0;
    if (!clr) begin
      m_d1 = '0; m_d2 = '0; m_held = 0; m_run = 0; m_rel = 0; m_cand = -1;
      return;
    end
    k = single_index(m_d2);
    if (m_held) begin
      if (m_d2 == (one << m_key)) m_rel = 0;
      else begin
        m_rel++;
        if (m_rel == D) begin m_held = 0; m_rel = 0; end
      end
    end else if (m_run > 0) begin
      if (!en && k == m_cand) begin
        m_run++;
        if (m_run == D) begin
          m_held = 1; m_key = m_cand; m_valid = 1; m_run = 0; m_rel = 0;
        end
      end else m_run = 0;
    end else if (!en && k >= 0) begin
      m_cand = k;
      m_run  = 1;
    end
    m_d2 = m_d1;
    m_d1 = r;
  endtask

  int            edge_no = 0, vcount = 0, last_v = -1, nz = 0, off = 0;
  logic [NK-1:0] watch = '0;

  task automatic mark();
    edge_no = 0; vcount = 0; last_v = -1; nz = 0; off = 0;
  endtask

  task automatic step(input logic [NK-1:0] r, input logic en, input logic clr);
    raw_keys = r;
    enablen  = en;
    clearn   = clr;
    @(posedge clock);
    model_edge(r, en, clr);
    #1;
    edge_no++;
    if (key_valid) begin vcount++; last_v = edge_no; end
    if (keypad != '0) nz++;
    if (keypad != watch) off++;
    check("model_keypad", 32'(keypad), 32'(m_keypad()));
    check("model_code", 32'(key_code), m_held ? 32'(m_key) : 32'hF);
    check("model_valid", 32'(key_valid), 32'(m_valid));
    check("model_held", 32'(key_held), 32'(m_held));
  endtask

  typedef struct {
    logic          clr;
    logic          en;
    logic [NK-1:0] raw;
    logic [NK-1:0] kp;
    logic [3:0]    code;
    logic          valid;
    logic          held;
  } vec_t;

  vec_t vt[14];

  initial begin
    logic [NK-1:0] one;
    logic          bpat[5];
    int            kind, len, a, b;
    logic          en_r, clr_r;
    logic [NK-1:0] pat;
    one = NK'(1);

    // Clean press of key 5 and its release: accept and clear both on edge D+2.
    vt[0]  = '{1'b0, 1'b0, 10'h000, 10'h000, 4'hF, 1'b0, 1'b0};
    vt[1]  = '{1'b1, 1'b0, 10'h020, 10'h000, 4'hF, 1'b0, 1'b0};
    vt[2]  = '{1'b1, 1'b0, 10'h020, 10'h000, 4'hF, 1'b0, 1'b0};
    vt[3]  = '{1'b1, 1'b0, 10'h020, 10'h000, 4'hF, 1'b0, 1'b0};
    vt[4]  = '{1'b1, 1'b0, 10'h020, 10'h000, 4'hF, 1'b0, 1'b0};
    vt[5]  = '{1'b1, 1'b0, 10'h020, 10'h020, 4'h5, 1'b1, 1'b1};
    vt[6]  = '{1'b1, 1'b0, 10'h020, 10'h020, 4'h5, 1'b0, 1'b1};
    vt[7]  = '{1'b1, 1'b0, 10'h020, 10'h020, 4'h5, 1'b0, 1'b1};
    vt[8]  = '{1'b1, 1'b0, 10'h000, 10'h020, 4'h5, 1'b0, 1'b1};
    vt[9]  = '{1'b1, 1'b0, 10'h000, 10'h020, 4'h5, 1'b0, 1'b1};
    vt[10] = '{1'b1, 1'b0, 10'h000, 10'h020, 4'h5, 1'b0, 1'b1};
    vt[11] = '{1'b1, 1'b0, 10'h000, 10'h020, 4'h5, 1'b0, 1'b1};
    vt[12] = '{1'b1, 1'b0, 10'h000, 10'h000, 4'hF, 1'b0, 1'b0};
    vt[13] = '{1'b1, 1'b0, 10'h000, 10'h000, 4'hF, 1'b0, 1'b0};

    step('0, 1'b0, 1'b0);
    for (int i = 0; i < 14; i++) begin
      step(vt[i].raw, vt[i].en, vt[i].clr);
      check("tbl_keypad", 32'(keypad), 32'(vt[i].kp));
      check("tbl_code", 32'(key_code), 32'(vt[i].code));
      check("tbl_valid", 32'(key_valid), 32'(vt[i].valid));
      check("tbl_held", 32'(key_held), 32'(vt[i].held));
    end

    // Bounce on key 2, then steady press.
    bpat = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    mark();
    for (int i = 0; i < 5; i++) step(bpat[i] ? 10'h004 : 10'h000, 1'b0, 1'b1);
    check("bounce_no_valid", 32'(vcount), 32'd0);
    mark();
    for (int i = 0; i < 10; i++) step(10'h004, 1'b0, 1'b1);
    check("bounce_valid_count", 32'(vcount), 32'd1);
    check("bounce_valid_edge", 32'(last_v), 32'(D + 2));
    check("bounce_code", 32'(key_code), 32'd2);
    for (int i = 0; i < 8; i++) step('0, 1'b0, 1'b1);

    // Two keys from idle are ignored; the survivor needs a fresh debounce.
    mark();
    for (int i = 0; i < 20; i++) step(10'h003, 1'b0, 1'b1);
    check("multi_no_valid", 32'(vcount), 32'd0);
    check("multi_keypad_zero", 32'(nz), 32'd0);
    mark();
    for (int i = 0; i < 10; i++) step(10'h001, 1'b0, 1'b1);
    check("multi_valid_count", 32'(vcount), 32'd1);
    check("multi_valid_edge", 32'(last_v), 32'(D + 2));
    check("multi_code", 32'(key_code), 32'd0);
    for (int i = 0; i < 8; i++) step('0, 1'b0, 1'b1);

    // Lockout: key 7 held while locked, then unlocked with the synchroniser full,
    // so the first unlocked edge is already the first debounce sample.
    mark();
    for (int i = 0; i < 20; i++) step(10'h080, 1'b1, 1'b1);
    check("lock_no_valid", 32'(vcount), 32'd0);
    mark();
    for (int i = 0; i < 10; i++) step(10'h080, 1'b0, 1'b1);
    check("lock_valid_count", 32'(vcount), 32'd1);
    check("lock_valid_edge", 32'(last_v), 32'(D));
    check("lock_code", 32'(key_code), 32'd7);
    for (int i = 0; i < 8; i++) step('0, 1'b0, 1'b1);

    // Key 3 accepted, then lockout asserted: hold and release run normally.
    mark();
    for (int i = 0; i < 8; i++) step(10'h008, 1'b0, 1'b1);
    check("lock3_valid_count", 32'(vcount), 32'd1);
    watch = 10'h008;
    mark();
    for (int i = 0; i < 10; i++) step(10'h008, 1'b1, 1'b1);
    check("lock3_keypad_held", 32'(off), 32'd0);
    for (int e = 1; e <= D + 3; e++) begin
      step('0, 1'b1, 1'b1);
      if (e == D + 1) check("lock3_still_held", 32'(keypad), 32'h008);
      if (e == D + 2) check("lock3_cleared", 32'(keypad), 32'h000);
    end

    // Short release glitch on key 9.
    for (int i = 0; i < 8; i++) step(10'h200, 1'b0, 1'b1);
    watch = 10'h200;
    mark();
    step('0, 1'b0, 1'b1);
    step('0, 1'b0, 1'b1);
    for (int i = 0; i < 10; i++) step(10'h200, 1'b0, 1'b1);
    check("glitch_keypad_held", 32'(off), 32'd0);
    check("glitch_no_valid", 32'(vcount), 32'd0);
    for (int i = 0; i < 8; i++) step('0, 1'b0, 1'b1);

    // Reset during a hold of key 4.
    for (int i = 0; i < 8; i++) step(10'h010, 1'b0, 1'b1);
    step(10'h010, 1'b0, 1'b0);
    check("rst_keypad", 32'(keypad), 32'h000);
    check("rst_code", 32'(key_code), 32'hF);
    check("rst_valid", 32'(key_valid), 32'd0);
    check("rst_held", 32'(key_held), 32'd0);
    mark();
    for (int i = 0; i < 10; i++) step(10'h010, 1'b0, 1'b1);
    check("rst_rearm_count", 32'(vcount), 32'd1);
    check("rst_rearm_edge", 32'(last_v), 32'(D + 2));
    for (int i = 0; i < 8; i++) step('0, 1'b0, 1'b1);

    // Randomised segments: single keys, idle, key pairs and noise.
    for (int seg = 0; seg < 200; seg++) begin
      kind = $urandom_range(0, 5);
      len  = $urandom_range(1, 10);
      en_r = ($urandom_range(0, 4) == 0);
      a    = $urandom_range(0, NK - 1);
      b    = $urandom_range(0, NK - 1);
      case (kind)
        0:       pat = '0;
        1, 2, 3: pat = one << a;
        4:       pat = (one << a) | (one << b);
        default: pat = NK'($urandom);
      endcase
      for (int c = 0; c < len; c++) begin
        clr_r = ($urandom_range(0, 79) != 0);
        if (kind == 5) pat = NK'($urandom);
        step(pat, en_r, clr_r);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not complete, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
`default_nettype wire
